// File: rtl/instr_decode.sv
// Instruction-stream decoder: gathers an opcode plus up to two extension
// words and presents the decoded instruction until the consumer takes it.
module instr_decode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ir,
  output logic [9:0]  out_op,
  output logic [2:0]  out_src_mode,
  output logic [2:0]  out_src_reg,
  output logic [2:0]  out_dst_mode,
  output logic [2:0]  out_dst_reg,
  output logic [15:0] out_ext1,
  output logic [15:0] out_ext2,
  output logic [1:0]  out_nwords,
  output logic        out_illegal
);

  typedef enum logic [1:0] {
    OPC, EXT1, EXT2, HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ext1_q, ext1_d;
  logic [15:0] ext2_q, ext2_d;
  logic [1:0]  nw_q, nw_d;
  logic        ill_q, ill_d;

  logic [6:0]  op7;
  logic [9:0]  op10;
  logic        is_jsr, is_jmp;
  logic        is_dbl, is_dst;
  logic        dec_ill;
  logic        src_need, dst_need;
  logic [1:0]  dec_nw;

  // Indexed/deferred modes and PC immediate/absolute carry an extra word
  function automatic logic needs_ext(
    input logic [2:0] mode,
    input logic [2:0] rg
  );
    return (mode >= 3'd6) ||
           (rg == 3'd7 && mode[2:1] == 2'b01);
  endfunction

  assign op7    = in_data[15:9];
  assign op10   = in_data[15:6];
  assign is_jsr = (op7 == 7'o004);
  assign is_jmp = (op10 == 10'o0001);
  assign is_dbl = (in_data[14:12] != 3'd0) &&
                  (in_data[14:12] != 3'd7);
  assign is_dst = is_jsr || is_jmp ||
                  (op7 >= 7'o070 && op7 <= 7'o074) ||
                  (op10 == 10'o0003) ||
                  (op10 >= 10'o0050 && op10 <= 10'o0063) ||
                  (op10 == 10'o0067) ||
                  (op10 >= 10'o1050 && op10 <= 10'o1064) ||
                  (op10 == 10'o1067);
  assign dec_ill = (in_data[15:12] == 4'hf) ||
                   ((is_jmp || is_jsr) &&
                    in_data[5:3] == 3'd0);

  assign src_need = needs_ext(in_data[11:9], in_data[8:6]);
  assign dst_need = needs_ext(in_data[5:3], in_data[2:0]);

  always_comb begin
    dec_nw = 2'd0;
    priority case (1'b1)
      dec_ill: dec_nw = 2'd0;
      is_dbl:  dec_nw = {1'b0, src_need} + {1'b0, dst_need};
      is_dst:  dec_nw = {1'b0, dst_need};
      default: dec_nw = 2'd0;
    endcase
  end

  assign in_ready = reset_n && !flush && (state_q != HOLD);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ext1_d  = ext1_q;
    ext2_d  = ext2_q;
    nw_d    = nw_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = OPC;
    end else begin
      unique case (state_q)
        OPC: if (in_valid) begin
          ir_d    = in_data;
          ext1_d  = 16'd0;
          ext2_d  = 16'd0;
          ill_d   = dec_ill;
          nw_d    = dec_nw;
          state_d = (dec_nw != 2'd0) ? EXT1 : HOLD;
        end
        EXT1: if (in_valid) begin
          ext1_d  = in_data;
          state_d = (nw_q == 2'd2) ? EXT2 : HOLD;
        end
        EXT2: if (in_valid) begin
          ext2_d  = in_data;
          state_d = HOLD;
        end
        HOLD: if (out_ready) begin
          state_d = OPC;
        end
        default: state_d = OPC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= OPC;
      ir_q    <= 16'd0;
      ext1_q  <= 16'd0;
      ext2_q  <= 16'd0;
      nw_q    <= 2'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ext1_q  <= ext1_d;
      ext2_q  <= ext2_d;
      nw_q    <= nw_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign out_ir       = ir_q;
  assign out_op       = ir_q[15:6];
  assign out_src_mode = ir_q[11:9];
  assign out_src_reg  = ir_q[8:6];
  assign out_dst_mode = ir_q[5:3];
  assign out_dst_reg  = ir_q[2:0];
  assign out_ext1     = ext1_q;
  assign out_ext2     = ext2_q;
  assign out_nwords   = nw_q;
  assign out_illegal  = ill_q;

endmodule

// File: tb/tb_instr_decode.sv
// Randomised bench for instr_decode against an arithmetic decode model
// plus directed opcode, stall, flush, illegal and reset sequences.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [9:0]  out_op;
  logic [2:0]  out_src_mode, out_src_reg;
  logic [2:0]  out_dst_mode, out_dst_reg;
  logic [15:0] out_ext1, out_ext2;
  logic [1:0]  out_nwords;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ir       (out_ir),
    .out_op       (out_op),
    .out_src_mode (out_src_mode),
    .out_src_reg  (out_src_reg),
    .out_dst_mode (out_dst_mode),
    .out_dst_reg  (out_dst_reg),
    .out_ext1     (out_ext1),
    .out_ext2     (out_ext2),
    .out_nwords   (out_nwords),
    .out_illegal  (out_illegal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int need(input int m, input int r);
    return (m >= 6 || (r == 7 && (m == 2 || m == 3))) ? 1 : 0;
  endfunction

  // Reference decode using integer octal-digit arithmetic
  function automatic void model(input int w,
                                output int nw,
                                output int ill);
    int op7, op10, sm, sr, dm, dr, grp;
    bit dbl, dst;
    op7  = w / 512;
    op10 = w / 64;
    sm   = (w / 512) % 8;
    sr   = (w / 64) % 8;
    dm   = (w / 8) % 8;
    dr   = w % 8;
    grp  = (w / 4096) % 8;
    ill  = ((w / 4096) == 15 ||
            ((op10 == 1 || op7 == 4) && dm == 0)) ? 1 : 0;
    dbl  = (grp >= 1 && grp <= 6);
    dst  = (op7 == 4) || (op7 >= 'o70 && op7 <= 'o74) ||
           op10 == 1 || op10 == 3 ||
           (op10 >= 'o50 && op10 <= 'o63) || op10 == 'o67 ||
           (op10 >= 'o1050 && op10 <= 'o1064) ||
           op10 == 'o1067;
    if (ill != 0)  nw = 0;
    else if (dbl)  nw = need(sm, sr) + need(dm, dr);
    else if (dst)  nw = need(dm, dr);
    else           nw = 0;
  endfunction

  task automatic check_out(input int w0, input int w1,
                           input int w2, input int nw,
                           input int ill, input string t);
    check({t, "_valid"}, 32'(out_valid), 1);
    check({t, "_ir"}, 32'(out_ir), w0);
    check({t, "_op"}, 32'(out_op), w0 / 64);
    check({t, "_smode"}, 32'(out_src_mode), (w0 / 512) % 8);
    check({t, "_sreg"}, 32'(out_src_reg), (w0 / 64) % 8);
    check({t, "_dmode"}, 32'(out_dst_mode), (w0 / 8) % 8);
    check({t, "_dreg"}, 32'(out_dst_reg), w0 % 8);
    check({t, "_ext1"}, 32'(out_ext1), (nw >= 1) ? w1 : 0);
    check({t, "_ext2"}, 32'(out_ext2), (nw == 2) ? w2 : 0);
    check({t, "_nwords"}, 32'(out_nwords), nw);
    check({t, "_illegal"}, 32'(out_illegal), ill);
  endtask

  task automatic check_zero(input string t);
    check({t, "_valid"}, 32'(out_valid), 0);
    check({t, "_ir"}, 32'(out_ir), 0);
    check({t, "_op"}, 32'(out_op), 0);
    check({t, "_fields"}, 32'({out_src_mode, out_src_reg,
                               out_dst_mode, out_dst_reg}), 0);
    check({t, "_ext1"}, 32'(out_ext1), 0);
    check({t, "_ext2"}, 32'(out_ext2), 0);
    check({t, "_nwords"}, 32'(out_nwords), 0);
    check({t, "_illegal"}, 32'(out_illegal), 0);
  endtask

  // Entered and left at a falling edge with the decoder awaiting an opcode
  task automatic run_instr(input logic [15:0] w0,
                           input logic [15:0] w1,
                           input logic [15:0] w2,
                           input int stall, input int gap,
                           input string t);
    int nw, ill;
    logic [15:0] words [3];
    model(int'(w0), nw, ill);
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    for (int i = 0; i <= nw; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          check({t, "_gapvalid"}, 32'(out_valid), 0);
          check({t, "_gapready"}, 32'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      in_data  = words[i];
      #1;
      check({t, "_inready"}, 32'(in_ready), 1);
      check({t, "_early"}, 32'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    #1;
    check_out(int'(w0), int'(w1), int'(w2), nw, ill, t);
    repeat (stall) begin
      @(negedge clk);
      check_out(int'(w0), int'(w1), int'(w2), nw, ill,
                {t, "_stall"});
      check({t, "_stallready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check({t, "_posths"}, 32'(out_valid), 0);
    check({t, "_postready"}, 32'(in_ready), 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'o012700;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 0);
    @(negedge clk);
    check_zero("rst");
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_rel_ready", 32'(in_ready), 1);

    run_instr(16'o012700, 16'o001234, 16'd0, 0, 0, "mov_imm");
    run_instr(16'o066162, 16'o000004, 16'o000006, 0, 0, "add_idx");
    run_instr(16'o001003, 16'd0, 16'd0, 3, 0, "bne_stall");

    in_valid = 1'b1;
    in_data  = 16'o012737;
    @(negedge clk);
    flush   = 1'b1;
    in_data = 16'o000005;
    #1;
    check("flush_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("flush_idle", 32'(out_valid), 0);
    run_instr(16'o005000, 16'd0, 16'd0, 0, 0, "clr");

    run_instr(16'o170000, 16'o1, 16'o2, 1, 0, "ill_f");
    run_instr(16'o000103, 16'o1, 16'o2, 0, 0, "ill_jmp");
    run_instr(16'o004200, 16'o1, 16'o2, 0, 0, "ill_jsr");
    run_instr(16'o005001, 16'd0, 16'd0, 0, 0, "clr_r1");
    run_instr(16'o004767, 16'o100, 16'd0, 0, 2, "jsr_pc");

    in_valid = 1'b1;
    in_data  = 16'o066767;
    @(negedge clk);
    in_data = 16'o000002;
    @(negedge clk);
    reset_n = 1'b0;
    in_data = 16'o000003;
    #1;
    check("midrst_ready", 32'(in_ready), 0);
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    check_zero("midrst");
    run_instr(16'o000240, 16'o1, 16'o2, 0, 0, "nop");

    for (int k = 0; k < 200; k++) begin
      run_instr(16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset_n  input  1  reset is synchronous and active-low.
REQ-003 in_valid  input  1  instruction-stream word available.
REQ-004 in_data  input  16  instruction or extension word.
REQ-005 in_ready  output  1  decoder accepts in_data this cycle; handshake = in_valid & in_ready.
REQ-006 flush  input  1  synchronous discard of the partial or held instruction, e.g. on a taken branch.
REQ-007 out_valid  output  1  decoded instruction held on out_*.
REQ-008 out_ready  input  1  consumer takes the instruction; handshake = out_valid & out_ready.
REQ-009 out_ir  output  16  opcode word.
REQ-010 out_op  output  10  ALU op code, = out_ir[15:6].
REQ-011 out_src_mode, out_src_reg, out_dst_mode, out_dst_reg  output  3 each  = ir[11:9], ir[8:6], ir[5:3], ir[2:0].
REQ-012 out_ext1, out_ext2  output  16 each  extension words in fetch order.
REQ-013 out_nwords  output  2  number of extension words, 0..2.
REQ-014 out_illegal  output  1  reserved or invalid encoding.

Function
REQ-015 FSM states: OPC (await opcode), EXT1, EXT2, HOLD.
REQ-016 in_ready SHALL be 1 in OPC, EXT1 and EXT2, and 0 in HOLD, during reset, or while flush=1.
REQ-017 OPC + word accepted: latch it into out_ir and compute the class. Next state is EXT1 if the word needs one or more extension words, else HOLD.
REQ-018 Class DOUBLE: ir[14:12] in 1..6. Both src and dst operands apply.
REQ-019 Class DST-only: ir[15:9] in octal 004 (JSR) or 070..074; or ir[15:6] in octal 0001, 0003, 0050..0063, 0067, 1050..1063, 1064 or 1067.
REQ-020 All other encodings have no operands and need no extension words. This includes branches, SOB, EMT/TRAP, condition-code ops and HALT.
REQ-021 An operand needs an extension word iff mode >= 6, or reg == 7 with mode 2 or 3.
REQ-022 Extension words are fetched source first, then destination.
REQ-023 out_nwords is computed at opcode accept as the sum of the operand needs.
REQ-024 EXT1 + word accepted: load out_ext1. Next state is EXT2 if out_nwords==2, else HOLD.
REQ-025 EXT2 + word accepted: load out_ext2; next state is HOLD.
REQ-026 out_valid SHALL be 1 exactly in HOLD.
REQ-027 In HOLD all out_* SHALL remain stable until the out handshake; the handshake returns the FSM to OPC.
REQ-028 Latency: out_valid rises the cycle after the last word of the instruction is accepted. Minimum period is (1 + nwords) + 1 cycles per instruction.
REQ-029 Unused ext registers SHALL be 0; they are cleared at each opcode accept.
REQ-030 Illegal encodings:
- ir[15:12] == 4'b1111;
- JMP (ir[15:6] == octal 0001) with dst mode 0;
- JSR (ir[15:9] == octal 004) with dst mode 0.
REQ-031 For an illegal encoding: out_illegal=1, out_nwords=0, and the FSM goes directly to HOLD.
REQ-032 flush=1 in any state SHALL force OPC next cycle and deassert out_valid. flush has priority over both handshakes; a word presented in that cycle is not consumed.
REQ-033 Waiting in EXT1 or EXT2 with in_valid=0 SHALL hold state indefinitely.

Reset
REQ-034 reset_n=0 at a clock edge SHALL force OPC from any state, including mid-instruction.
REQ-035 Reset values: out_valid=0, out_ir=0, out_op=0, all mode/reg fields 0, out_ext1=out_ext2=0, out_nwords=0, out_illegal=0.
REQ-036 Reset SHALL have priority over flush and both handshakes.
REQ-037 The first word accepted after reset SHALL be treated as an opcode.

Verification
REQ-038 Feed 012700, 001234 back-to-back with out_ready=1:
- out_valid rises 1 cycle after the second word;
- out_op=10'o0127, nwords=1, ext1=001234, ext2=0.
REQ-039 Feed 066162, 000004, 000006 (ADD 4(R1),6(R2)):
- nwords=2, ext1=4, ext2=6;
- src mode/reg 6/1, dst mode/reg 6/2.
REQ-040 Feed 001003 (BNE) with out_ready=0 for 3 cycles:
- nwords=0;
- out_* stable and in_ready=0 throughout the stall;
- handshake on the 4th cycle, then OPC.
REQ-041 Feed 012737, then assert flush in EXT1, then feed 005000:
- no output for the MOV;
- CLR decoded: op=10'o0050, nwords=0.
REQ-042 Feed 170000, then 000103:
- each yields out_illegal=1, nwords=0;
- next word 005001 decodes legal.
REQ-043 Pull reset_n low for one cycle while in EXT2 of 066767:
- out_valid=0 and all outputs 0;
- next word 000240 decodes as an opcode with nwords=0.
